// File: rtl/problema1_slew_pio.sv
// ============================================================================
//  Module   : problema1_slew_pio
//  Purpose  : Multi-channel Avalon-MM output port. Each channel holds a
//             software-written target; its output position either snaps to
//             the target every cycle (slew disabled) or walks toward it by a
//             programmable step on each prescaled tick (slew enabled).
//  Ports    : clk, reset       - clock, synchronous active-high reset
//             address[3:0]     - word address
//             chipselect       - slave select
//             write_n          - active-low write strobe
//             writedata[31:0]  - write data
//             readdata[31:0]   - combinational read data, zero-extended
//             out_port         - channel c position at [c*WIDTH +: WIDTH]
//             busy[CHANNELS]   - bit c high while pos[c] != target[c]
//  Register map: 2c TARGET[c], 2c+1 POS[c] (write = jump), 13 LIMIT,
//                14 CTRL ([0] slew_en, [15:8] step), 15 STATUS (busy)
//  Option   : define SLEW_PIO_LIMIT_EN for the R/W LIMIT register and
//             write-time saturation of TARGET/POS writes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module problema1_slew_pio #(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 2,
    parameter int PRESCALE = 50000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [3:0]                   address,
    input  logic                         chipselect,
    input  logic                         write_n,
    input  logic [31:0]                  writedata,
    output logic [31:0]                  readdata,
    output logic [CHANNELS*WIDTH-1:0]    out_port,
    output logic [CHANNELS-1:0]          busy
);

    localparam int               c_CNT_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    // Distance/step comparisons are done wide enough for both a position
    // and the 8-bit step, so nothing can overflow or wrap.
    localparam int               c_ARITH_W    = ((WIDTH > 8) ? WIDTH : 8) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(PRESCALE - 1);
    localparam logic [3:0]       c_ADDR_LIMIT  = 4'd13;
    localparam logic [3:0]       c_ADDR_CTRL   = 4'd14;
    localparam logic [3:0]       c_ADDR_STATUS = 4'd15;

    logic [WIDTH-1:0]   r_target [CHANNELS];
    logic [WIDTH-1:0]   r_pos    [CHANNELS];
    logic               r_slew_en;
    logic [7:0]         r_step;
    logic [c_CNT_W-1:0] r_count;

    logic               w_wr;
    logic               w_tick;
    logic               w_ctrl_wr;
    logic [WIDTH-1:0]   w_wval;
    logic [WIDTH-1:0]   w_limit;
    logic [WIDTH-1:0]   w_step_pos [CHANNELS];
    logic               w_unused;

    assign w_wr      = chipselect && !write_n;
    assign w_tick    = (r_count == c_CNT_LAST);
    assign w_ctrl_wr = w_wr && (address == c_ADDR_CTRL);
    // Upper write-data bits are don't-care for most registers.
    assign w_unused  = ^writedata;

`ifdef SLEW_PIO_LIMIT_EN
    logic [WIDTH-1:0] r_limit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_limit <= '1;
        end else if (w_wr && (address == c_ADDR_LIMIT)) begin
            r_limit <= writedata[WIDTH-1:0];
        end
    end

    assign w_limit = r_limit;
    // Saturation compares the full 32-bit write value, so large values clamp
    // rather than being truncated first.
    assign w_wval  = (writedata > 32'(r_limit)) ? r_limit : writedata[WIDTH-1:0];
`else
    assign w_limit = '0;
    assign w_wval  = writedata[WIDTH-1:0];
`endif

    // Candidate position after one slew step, clamped at the target.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_step_pos[c] = r_pos[c];
            if (r_pos[c] < r_target[c]) begin
                if (c_ARITH_W'(r_target[c] - r_pos[c]) <= c_ARITH_W'(r_step)) begin
                    w_step_pos[c] = r_target[c];
                end else begin
                    // Remaining distance exceeds the step, so the step fits in WIDTH bits.
                    w_step_pos[c] = r_pos[c] + WIDTH'(r_step);
                end
            end else if (r_pos[c] > r_target[c]) begin
                if (c_ARITH_W'(r_pos[c] - r_target[c]) <= c_ARITH_W'(r_step)) begin
                    w_step_pos[c] = r_target[c];
                end else begin
                    w_step_pos[c] = r_pos[c] - WIDTH'(r_step);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_target[c] <= '0;
                r_pos[c]    <= '0;
            end
            r_slew_en <= 1'b0;
            r_step    <= '0;
            r_count   <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_slew_en <= writedata[0];
                r_step    <= writedata[15:8];
            end

            // A CTRL write restarts the tick period; a coincident tick has
            // already been consumed with the old step below.
            if (w_ctrl_wr || w_tick) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + c_CNT_W'(1);
            end

            for (int c = 0; c < CHANNELS; c++) begin
                if (w_wr && (address == 4'(2*c + 1))) begin
                    // Jump: loads both registers, overriding any step.
                    r_pos[c]    <= w_wval;
                    r_target[c] <= w_wval;
                end else begin
                    // Position moves toward the target held before this edge.
                    if (!r_slew_en) begin
                        r_pos[c] <= r_target[c];
                    end else if (w_tick) begin
                        r_pos[c] <= w_step_pos[c];
                    end
                    if (w_wr && (address == 4'(2*c))) begin
                        r_target[c] <= w_wval;
                    end
                end
            end
        end
    end

    always_comb begin
        out_port = '0;
        busy     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            out_port[c*WIDTH +: WIDTH] = r_pos[c];
            busy[c]                    = (r_pos[c] != r_target[c]);
        end
    end

    always_comb begin
        readdata = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (address == 4'(2*c)) begin
                readdata = 32'(r_target[c]);
            end
            if (address == 4'(2*c + 1)) begin
                readdata = 32'(r_pos[c]);
            end
        end
        case (address)
            c_ADDR_LIMIT:  readdata = 32'(w_limit);
            c_ADDR_CTRL:   readdata = {16'd0, r_step, 7'd0, r_slew_en};
            c_ADDR_STATUS: readdata = 32'(busy);
            default:       ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_problema1_slew_pio.sv
// ============================================================================
//  Module   : tb_problema1_slew_pio
//  Purpose  : Self-checking bench for problema1_slew_pio. Directed scenarios
//             followed by randomized bus traffic, all compared against a
//             cycle-level behavioural model of targets, positions and ticks.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_problema1_slew_pio;

    localparam int W  = 10;
    localparam int CH = 2;
    localparam int PS = 4;
`ifdef SLEW_PIO_LIMIT_EN
    localparam logic [31:0] c_LIM_RST = 32'h3FF;
`else
    localparam logic [31:0] c_LIM_RST = 32'h0;
`endif

    logic              clk;
    logic              reset;
    logic [3:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [CH*W-1:0]   out_port;
    logic [CH-1:0]     busy;

    problema1_slew_pio #(
        .WIDTH    (W),
        .CHANNELS (CH),
        .PRESCALE (PS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_valid = 0;
    int m_tgt [CH];
    int m_pos [CH];
    int m_slew, m_step, m_cnt, m_limit;

    function automatic logic [31:0] model_read(input logic [3:0] a);
        logic [31:0] r;
        r = 0;
        if (int'(a) < 2*CH) begin
            r = a[0] ? 32'(m_pos[int'(a) / 2]) : 32'(m_tgt[int'(a) / 2]);
        end else if (a == 4'd13) begin
`ifdef SLEW_PIO_LIMIT_EN
            r = 32'(m_limit);
`endif
        end else if (a == 4'd14) begin
            r = 32'(m_step * 256 + m_slew);
        end else if (a == 4'd15) begin
            for (int c = 0; c < CH; c++) if (m_pos[c] != m_tgt[c]) r = r + 32'(1 << c);
        end
        return r;
    endfunction

    function automatic logic [31:0] model_out();
        logic [31:0] e;
        e = 0;
        for (int c = 0; c < CH; c++) e = e | (32'(m_pos[c]) << (c*W));
        return e;
    endfunction

    task automatic model_step(input logic cs, input logic wn, input logic [3:0] a,
                              input logic [31:0] d, input logic rs);
        bit wr, tick;
        int wv, p, t, np;
        if (rs) begin
            m_valid = 1;
            for (int c = 0; c < CH; c++) begin m_tgt[c] = 0; m_pos[c] = 0; end
            m_slew = 0; m_step = 0; m_cnt = 0; m_limit = (1 << W) - 1;
            return;
        end
        if (!m_valid) return;
        wr   = cs && !wn;
        tick = (m_cnt == PS - 1);
`ifdef SLEW_PIO_LIMIT_EN
        wv = (d > 32'(m_limit)) ? m_limit : int'(d % (1 << W));
`else
        wv = int'(d % (1 << W));
`endif
        for (int c = 0; c < CH; c++) begin
            if (wr && int'(a) == 2*c + 1) begin
                m_pos[c] = wv; m_tgt[c] = wv;
            end else begin
                p = m_pos[c]; t = m_tgt[c]; np = p;
                if (m_slew == 0) np = t;
                else if (tick) begin
                    if (p < t)      np = (p + m_step < t) ? p + m_step : t;
                    else if (p > t) np = (p - m_step > t) ? p - m_step : t;
                end
                m_pos[c] = np;
                if (wr && int'(a) == 2*c) m_tgt[c] = wv;
            end
        end
        if (wr && a == 4'd14) begin
            m_slew = int'(d[0]); m_step = int'(d[15:8]); m_cnt = 0;
        end else begin
            m_cnt = tick ? 0 : m_cnt + 1;
        end
`ifdef SLEW_PIO_LIMIT_EN
        if (wr && a == 4'd13) m_limit = int'(d % (1 << W));
`endif
    endtask

    // One bus cycle: drive inputs, check read path, advance one edge, check outputs.
    task automatic cyc(input logic cs, input logic wn, input logic [3:0] a,
                       input logic [31:0] d, input logic rs);
        chipselect = cs; write_n = wn; address = a; writedata = d; reset = rs;
        #1;
        if (m_valid) check_val("readdata", readdata, model_read(a));
        model_step(cs, wn, a, d, rs);
        @(posedge clk);
        #1;
        if (m_valid) begin
            check_val("out_port", 32'(out_port), model_out());
            check_val("busy", 32'(busy), model_read(4'd15));
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b1, 4'd0, 32'd0, 1'b0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
        chipselect = 1'b1; write_n = 1'b1; address = a; reset = 1'b0;
        #1;
        check_val(tag, readdata, exp);
    endtask

    initial begin
        logic [3:0]  ra;
        logic [31:0] rdat;
        logic        rwn, rrs;
        int          pe;

        chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0; reset = 1'b1;
        @(posedge clk); #1;
        cyc(1'b0, 1'b1, 4'd0, 32'd0, 1'b1);

        // Reset state
        check_val("reset_out", 32'(out_port), 32'd0);
        check_val("reset_busy", 32'(busy), 32'd0);
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), (a == 13) ? c_LIM_RST : 32'd0, "reset_read");
            idle();
        end

        // Snap mode: target appears two edges after the write
        cyc(1'b1, 1'b0, 4'd2, 32'h155, 1'b0);
        check_val("snap_busy_hi", 32'(busy), 32'h2);
        idle();
        check_val("snap_out", 32'(out_port[19:10]), 32'h155);
        check_val("snap_busy_lo", 32'(busy), 32'h0);

        // Slew up by 3 toward 10
        cyc(1'b1, 1'b0, 4'd14, 32'h0301, 1'b0);
        cyc(1'b1, 1'b0, 4'd0, 32'd10, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            idle();
            pe = (k < 3) ? 0 : (k < 7) ? 3 : (k < 11) ? 6 : (k < 15) ? 9 : 10;
            check_val("ramp_up_pos", 32'(out_port[9:0]), 32'(pe));
            check_val("ramp_up_busy", 32'(busy[0]), (pe != 10) ? 32'd1 : 32'd0);
        end

        // Slew down by 4 toward 0, then jump coinciding with a tick
        cyc(1'b1, 1'b0, 4'd14, 32'h0401, 1'b0);
        cyc(1'b1, 1'b0, 4'd0, 32'd0, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            idle();
            pe = (k < 3) ? 10 : (k < 7) ? 6 : (k < 11) ? 2 : 0;
            check_val("ramp_dn_pos", 32'(out_port[9:0]), 32'(pe));
        end
        cyc(1'b1, 1'b0, 4'd1, 32'h3FF, 1'b0);
        check_val("jump_pos", 32'(out_port[9:0]), 32'h3FF);
        check_val("jump_busy", 32'(busy), 32'h0);
        rd(4'd0, 32'h3FF, "jump_tgt");

        // Target write coinciding with a tick steps toward the old target
        cyc(1'b1, 1'b0, 4'd14, 32'h0301, 1'b0);
        cyc(1'b1, 1'b0, 4'd0, 32'h100, 1'b0);
        idle(); idle();
        cyc(1'b1, 1'b0, 4'd0, 32'h3FF, 1'b0);
        check_val("tick_tw_pos", 32'(out_port[9:0]), 32'h3FC);
        rd(4'd0, 32'h3FF, "tick_tw_tgt");
        idle(); idle(); idle();
        check_val("tick_tw_hold", 32'(out_port[9:0]), 32'h3FC);
        idle();
        check_val("tick_tw_new", 32'(out_port[9:0]), 32'h3FF);

        // Reset mid-slew wins over a simultaneous write
        cyc(1'b1, 1'b0, 4'd0, 32'd0, 1'b0);
        for (int k = 0; k < 5; k++) idle();
        cyc(1'b1, 1'b0, 4'd2, 32'h55, 1'b1);
        check_val("rst_mid_out", 32'(out_port), 32'd0);
        check_val("rst_mid_busy", 32'(busy), 32'd0);
        rd(4'd14, 32'd0, "rst_mid_ctrl");
        rd(4'd2, 32'd0, "rst_mid_tgt1");

        // LIMIT behaviour
        cyc(1'b1, 1'b0, 4'd13, 32'h200, 1'b0);
        cyc(1'b1, 1'b0, 4'd0, 32'h3FF, 1'b0);
`ifdef SLEW_PIO_LIMIT_EN
        rd(4'd0, 32'h200, "limit_sat");
        rd(4'd13, 32'h200, "limit_read");
        cyc(1'b1, 1'b0, 4'd13, 32'h3FF, 1'b0);
`else
        rd(4'd0, 32'h3FF, "limit_nosat");
        rd(4'd13, 32'h0, "limit_read");
        idle();
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rrs = ($urandom_range(0, 199) == 0);
            rwn = ($urandom_range(0, 9) < 4);
            ra  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       rdat = $urandom;
                default: rdat = 32'($urandom_range(0, (1 << W) - 1));
            endcase
            if (ra == 4'd14) begin
                rdat[15:8] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
                rdat[0]    = ($urandom_range(0, 4) != 0);
            end
            cyc(1'b1, rwn, ra, rdat, rrs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
